// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register-file write-back arbiter. ALU results win by default;
//               MAC results queue in an in-order FIFO and are drained when
//               the ALU is idle or has starved the FIFO for STARVE_LIMIT wins.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int NUM_ADDR_BITS = 6,
    parameter int REG_WIDTH     = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [NUM_ADDR_BITS-1:0]      alu_addr,
    input  logic [REG_WIDTH-1:0]          alu_data,

    input  logic                          mac_valid,
    output logic                          mac_ready,
    input  logic [NUM_ADDR_BITS-1:0]      mac_addr,
    input  logic [REG_WIDTH-1:0]          mac_data,

    output logic                          writeEnable,
    output logic [NUM_ADDR_BITS-1:0]      wrAddr,
    output logic [REG_WIDTH-1:0]          wrData,
    output logic [$clog2(FIFO_DEPTH):0]   mac_pending
);

    // FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
    localparam int c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W    = c_PTR_W + 1;
    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [c_CNT_W-1:0]    c_FULL       = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_ADDR_BITS-1:0] r_fifoAddr [FIFO_DEPTH];
    logic [REG_WIDTH-1:0]     r_fifoData [FIFO_DEPTH];
    logic [c_PTR_W-1:0]       r_wrPtr;
    logic [c_PTR_W-1:0]       r_rdPtr;
    logic [c_CNT_W-1:0]       r_count;
    logic [c_STARVE_W-1:0]    r_starveCnt;

    logic                     r_writeEnable;
    logic [NUM_ADDR_BITS-1:0] r_wrAddr;
    logic [REG_WIDTH-1:0]     r_wrData;

    // ------------------------------------------------------------------------
    // Handshake and selection
    // ------------------------------------------------------------------------
    logic                     w_fifoEmpty;
    logic                     w_fifoFull;
    logic                     w_starved;
    logic                     w_aluReady;
    logic                     w_macReady;
    logic                     w_aluXfer;
    logic                     w_macXfer;
    logic                     w_pop;
    logic [NUM_ADDR_BITS-1:0] w_headAddr;
    logic [REG_WIDTH-1:0]     w_headData;

    always_comb begin
        w_fifoEmpty = (r_count == '0);
        w_fifoFull  = (r_count == c_FULL);
        w_starved   = (r_starveCnt == c_STARVE_MAX) && !w_fifoEmpty;
        // Readiness depends only on registered state and reset, never on valid.
        w_aluReady  = !reset && !w_starved;
        w_macReady  = !reset && !w_fifoFull;
        w_aluXfer   = alu_valid && w_aluReady;
        w_macXfer   = mac_valid && w_macReady;
        // Pop decision uses the pre-push occupancy, so a push into an empty
        // FIFO can only leave on a later edge.
        w_pop       = !reset && !w_aluXfer && !w_fifoEmpty;
        w_headAddr  = r_fifoAddr[r_rdPtr];
        w_headData  = r_fifoData[r_rdPtr];
    end

    assign alu_ready   = w_aluReady;
    assign mac_ready   = w_macReady;
    assign writeEnable = r_writeEnable;
    assign wrAddr      = r_wrAddr;
    assign wrData      = r_wrData;
    assign mac_pending = r_count;

    // ------------------------------------------------------------------------
    // FIFO storage (contents need no reset; pointers and count define validity)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_macXfer) begin
            r_fifoAddr[r_wrPtr] <= mac_addr;
            r_fifoData[r_wrPtr] <= mac_data;
        end
    end

    // ------------------------------------------------------------------------
    // Control, pointers and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_starveCnt   <= '0;
            r_writeEnable <= 1'b0;
            r_wrAddr      <= '0;
            r_wrData      <= '0;
        end else begin
            if (w_aluXfer) begin
                r_writeEnable <= (alu_addr != '0);
                r_wrAddr      <= alu_addr;
                r_wrData      <= alu_data;
            end else if (w_pop) begin
                r_writeEnable <= (w_headAddr != '0);
                r_wrAddr      <= w_headAddr;
                r_wrData      <= w_headData;
            end else begin
                r_writeEnable <= 1'b0;
            end

            if (w_pop || w_fifoEmpty) begin
                r_starveCnt <= '0;
            end else if (w_aluXfer && (r_starveCnt != c_STARVE_MAX)) begin
                r_starveCnt <= r_starveCnt + 1'b1;
            end

            if (w_macXfer) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end

            case ({w_macXfer, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed and randomised bench for wb_arbiter with a queue
//               reference model and an expected-output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SL    = 3;

    logic          clk;
    logic          reset;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mac_valid;
    logic          mac_ready;
    logic [AW-1:0] mac_addr;
    logic [DW-1:0] mac_data;
    logic          writeEnable;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic [2:0]    mac_pending;

    wb_arbiter #(
        .NUM_ADDR_BITS(AW),
        .REG_WIDTH    (DW),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .mac_valid  (mac_valid),
        .mac_ready  (mac_ready),
        .mac_addr   (mac_addr),
        .mac_data   (mac_data),
        .writeEnable(writeEnable),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .mac_pending(mac_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    pend;
    } exp_t;

    ent_t          mq[$];
    exp_t          sbq[$];
    int            mStarve;
    logic          mWe;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mData;

    int            checks;
    int            failures;
    logic          obsAluRdy;
    logic          obsMacRdy;
    logic [2:0]    obsPend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, check readies, advance model,
    // then compare the registered outputs just after the posedge.
    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        logic expAluRdy;
        logic expMacRdy;
        logic aluX;
        logic macX;
        ent_t h;
        ent_t n;
        exp_t e;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mac_valid = mv; mac_addr = ma; mac_data = md;
        expAluRdy = !(mStarve == SL && mq.size() != 0);
        expMacRdy = (mq.size() != DEPTH);
        #1;
        obsAluRdy = alu_ready;
        obsMacRdy = mac_ready;
        obsPend   = mac_pending;
        chk("alu_ready", 32'(alu_ready), 32'(expAluRdy));
        chk("mac_ready", 32'(mac_ready), 32'(expMacRdy));
        aluX = av && expAluRdy;
        macX = mv && expMacRdy;
        if (aluX) begin
            mWe = (aa != 0); mAddr = aa; mData = ad;
            if (mq.size() != 0) mStarve = (mStarve < SL) ? mStarve + 1 : SL;
            else                mStarve = 0;
        end else if (mq.size() != 0) begin
            h = mq.pop_front();
            mWe = (h.a != 0); mAddr = h.a; mData = h.d;
            mStarve = 0;
        end else begin
            mWe = 1'b0;
            mStarve = 0;
        end
        if (macX) begin
            n.a = ma; n.d = md;
            mq.push_back(n);
        end
        e.we = mWe; e.addr = mAddr; e.data = mData; e.pend = 3'(mq.size());
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("writeEnable", 32'(writeEnable), 32'(e.we));
        chk("wrAddr",      32'(wrAddr),      32'(e.addr));
        chk("wrData",      wrData,           e.data);
        chk("mac_pending", 32'(mac_pending), 32'(e.pend));
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        alu_valid = 1'b0;
        mac_valid = 1'b0;
        #1;
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_mac_ready", 32'(mac_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_writeEnable", 32'(writeEnable), 32'd0);
        chk("rst_wrAddr",      32'(wrAddr),      32'd0);
        chk("rst_wrData",      wrData,           32'd0);
        chk("rst_mac_pending", 32'(mac_pending), 32'd0);
        mq.delete();
        mStarve = 0; mWe = 1'b0; mAddr = '0; mData = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mac_valid = 1'b0; mac_addr = '0; mac_data = '0;
        mStarve = 0; mWe = 1'b0; mAddr = '0; mData = '0;
        @(negedge clk);
        doReset();

        // ALU-only write, then a dropped write to register 0
        step(1'b1, 6'd5, 32'h1234_5678, 1'b0, '0, '0);
        chk("alu_we",   32'(writeEnable), 32'd1);
        chk("alu_addr", 32'(wrAddr),      32'd5);
        chk("alu_data", wrData,           32'h1234_5678);
        chk("alu_rdy",  32'(obsAluRdy),   32'd1);
        step(1'b1, 6'd0, 32'hFFFF_FFFF, 1'b0, '0, '0);
        chk("r0_we",  32'(writeEnable), 32'd0);
        chk("r0_rdy", 32'(obsAluRdy),   32'd1);
        idle();
        chk("idle_we",   32'(writeEnable), 32'd0);
        chk("idle_data", wrData,           32'hFFFF_FFFF);

        // FIFO fill with a starving ALU
        doReset();
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 6'd9, 32'hA000 + i, 1'b1, 6'(i), 32'hB000 + i);
            if (i <= 4) chk("fill_mac_rdy_hi", 32'(obsMacRdy), 32'd1);
        end
        chk("fill_mac_rdy_lo", 32'(obsMacRdy), 32'd0);
        chk("fill_pend4",      32'(obsPend),   32'd4);
        chk("fill_alu_blk",    32'(obsAluRdy), 32'd0);
        chk("fill_pop_addr",   32'(wrAddr),    32'd1);
        chk("fill_pop_data",   wrData,         32'hB001);
        step(1'b1, 6'd9, 32'hA006, 1'b0, '0, '0);
        chk("starve_clear", 32'(obsAluRdy), 32'd1);
        chk("starve_win",   32'(wrAddr),    32'd9);
        for (int i = 0; i < 6; i++) step(1'b1, 6'd9, 32'hA100 + i, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) idle();
        chk("fill_empty", 32'(mac_pending), 32'd0);

        // Drain order with ALU stopped
        doReset();
        for (int i = 1; i <= 4; i++) step(1'b1, 6'd9, 32'hA000 + i, 1'b1, 6'(i), 32'hC000 + i);
        chk("drain_pend4", 32'(mac_pending), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            idle();
            chk("drain_we",   32'(writeEnable), 32'd1);
            chk("drain_addr", 32'(wrAddr),      32'(i));
        end
        idle();
        chk("drain_done_we",   32'(writeEnable), 32'd0);
        chk("drain_done_pend", 32'(mac_pending), 32'd0);

        // Simultaneous push and pop at occupancy 2
        doReset();
        step(1'b1, 6'd9, 32'hA001, 1'b1, 6'd1, 32'hD001);
        step(1'b1, 6'd9, 32'hA002, 1'b1, 6'd2, 32'hD002);
        step(1'b0, 6'd0, 32'h0,    1'b1, 6'd3, 32'hD003);
        chk("overlap_pend", 32'(mac_pending), 32'd2);
        chk("overlap_addr", 32'(wrAddr),      32'd1);
        chk("overlap_data", wrData,           32'hD001);

        // Reset mid-drain discards buffered results
        step(1'b1, 6'd9, 32'hA004, 1'b1, 6'd4, 32'hD004);
        chk("pre_rst_pend", 32'(mac_pending), 32'd3);
        doReset();
        idle();
        chk("post_rst_we1",   32'(writeEnable), 32'd0);
        chk("post_rst_pend1", 32'(mac_pending), 32'd0);
        idle();
        chk("post_rst_we2",   32'(writeEnable), 32'd0);

        // Random traffic against the model, including register-0 targets
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), DW'($urandom),
                 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), DW'($urandom));
        end
        for (int i = 0; i < 6; i++) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
